// File: rtl/chip_eval_sequencer.sv
// chip_eval_sequencer: runs one chip evaluation. It holds the chip in reset,
// releases it and pulses kernel_start. It then deserializes one selected
// serial stream (MSB first) into words. Captured words are buffered in a FIFO
// that is read over a valid/ready port.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   cmd_start           - run request (IDLE only)
//   cmd_stream_sel      - stream to capture (0..4, 5..7 = none)
//   cmd_bypass_adc      - value for bypass_adc_eval during the run
//   chip_eval_done      - chip completion level
//   chip_serial_data    - per-stream serial bits
//   chip_serial_valid   - per-stream bit strobes
//   sys_rst_n           - chip reset (active low)
//   kernel_start        - chip kernel start pulse
//   bypass_adc_eval     - chip ADC bypass control
//   word_data/valid     - FIFO head word / FIFO non-empty
//   word_ready          - consumer accepts head word
//   busy                - run in progress
//   done/timeout        - sticky run termination cause
//   overflow            - sticky, a word was dropped on a full FIFO
//   partial             - sticky, run ended with an incomplete word
module chip_eval_sequencer #(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned WORD_W         = 16,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic [2:0]        cmd_stream_sel,
    input  logic              cmd_bypass_adc,
    input  logic              chip_eval_done,
    input  logic [4:0]        chip_serial_data,
    input  logic [4:0]        chip_serial_valid,
    output logic              sys_rst_n,
    output logic              kernel_start,
    output logic              bypass_adc_eval,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic              partial
);

    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned BW = $clog2(WORD_W);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RESET = 2'd1;
    localparam logic [1:0] ST_START = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [2:0]        sel_q, sel_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;

    logic              sys_rst_n_q, sys_rst_n_d;
    logic              kernel_start_q, kernel_start_d;
    logic              bypass_q, bypass_d;
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic              word_valid_q, word_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;
    logic              partial_q, partial_d;

    logic              bit_valid, bit_data;
    logic              flush, push, push_ok, pop;
    logic [WORD_W-1:0] push_word;

    // Selected stream; selections 5..7 never present a bit.
    always_comb begin
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        case (sel_q)
            3'd0: begin bit_valid = chip_serial_valid[0]; bit_data = chip_serial_data[0]; end
            3'd1: begin bit_valid = chip_serial_valid[1]; bit_data = chip_serial_data[1]; end
            3'd2: begin bit_valid = chip_serial_valid[2]; bit_data = chip_serial_data[2]; end
            3'd3: begin bit_valid = chip_serial_valid[3]; bit_data = chip_serial_data[3]; end
            3'd4: begin bit_valid = chip_serial_valid[4]; bit_data = chip_serial_data[4]; end
            default: ;
        endcase
    end

    // Sequencer, deserializer and FIFO next-state logic.
    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        to_cnt_d       = to_cnt_q;
        sel_d          = sel_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        mem_d          = mem_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        fifo_cnt_d     = fifo_cnt_q;
        sys_rst_n_d    = sys_rst_n_q;
        kernel_start_d = kernel_start_q;
        bypass_d       = bypass_q;
        busy_d         = busy_q;
        done_d         = done_q;
        timeout_d      = timeout_q;
        overflow_d     = overflow_q;
        partial_d      = partial_q;
        flush          = 1'b0;
        push           = 1'b0;
        push_ok        = 1'b0;
        push_word      = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_d     = ST_RESET;
                    sel_d       = cmd_stream_sel;
                    bypass_d    = cmd_bypass_adc;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                    overflow_d  = 1'b0;
                    partial_d   = 1'b0;
                    flush       = 1'b1;
                    shreg_d     = '0;
                    bit_cnt_d   = '0;
                    rst_cnt_d   = '0;
                    sys_rst_n_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_RESET: begin
                // The release and the start pulse are registered on the last
                // reset cycle so they appear together in the START cycle.
                sys_rst_n_d = 1'b0;
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                    state_d        = ST_START;
                    sys_rst_n_d    = 1'b1;
                    kernel_start_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            ST_START: begin
                state_d        = ST_RUN;
                kernel_start_d = 1'b0;
                to_cnt_d       = '0;
            end
            default: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (bit_valid) begin
                    shreg_d = {shreg_q[WORD_W-2:0], bit_data};
                    if (bit_cnt_q == BW'(WORD_W - 1)) begin
                        push      = 1'b1;
                        push_word = {shreg_q[WORD_W-2:0], bit_data};
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                // A bit sampled with the terminating condition is counted
                // before the leftover check.
                if (chip_eval_done || (to_cnt_q == TW'(TIMEOUT_CYCLES))) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (chip_eval_done) begin
                        done_d = 1'b1;
                    end else begin
                        timeout_d = 1'b1;
                    end
                    if (bit_cnt_d != '0) begin
                        partial_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
        endcase

        pop = word_valid_q && word_ready && !flush;

        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (push) begin
                // A pop in the same cycle frees the slot for a full FIFO.
                if ((fifo_cnt_q != CW'(FIFO_DEPTH)) || pop) begin
                    push_ok         = 1'b1;
                    mem_d[wr_ptr_q] = push_word;
                    wr_ptr_d        = wr_ptr_q + AW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end

        word_valid_d = (fifo_cnt_d != '0);
        word_data_d  = word_valid_d ? mem_d[rd_ptr_d] : '0;
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rst_cnt_q      <= '0;
            to_cnt_q       <= '0;
            sel_q          <= '0;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            sys_rst_n_q    <= 1'b0;
            kernel_start_q <= 1'b0;
            bypass_q       <= 1'b0;
            word_data_q    <= '0;
            word_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            overflow_q     <= 1'b0;
            partial_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            to_cnt_q       <= to_cnt_d;
            sel_q          <= sel_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            sys_rst_n_q    <= sys_rst_n_d;
            kernel_start_q <= kernel_start_d;
            bypass_q       <= bypass_d;
            word_data_q    <= word_data_d;
            word_valid_q   <= word_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            timeout_q      <= timeout_d;
            overflow_q     <= overflow_d;
            partial_q      <= partial_d;
        end
    end

    // Word storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign sys_rst_n       = sys_rst_n_q;
    assign kernel_start    = kernel_start_q;
    assign bypass_adc_eval = bypass_q;
    assign word_data       = word_data_q;
    assign word_valid      = word_valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign timeout         = timeout_q;
    assign overflow        = overflow_q;
    assign partial         = partial_q;

endmodule
